nibble_distributor: RTL and testbench

Registered 1-to-4 distributor for 4-bit data: the write-side counterpart of the ALU's 4-to-1 nibble selector. It accepts a stream of nibbles over a valid/ready handshake and steers each one into one of four output registers Q0..Q3, either by explicit slot address or by an internal wrapping pointer. When all four slots hold fresh data, it presents them as one 16-bit frame and holds them until a consumer accepts the frame. It sits between the operand-entry path and the ALU operand registers.

---
 rtl/nibble_distributor_pkg.sv | 22 ++
 rtl/slot_reg4.sv | 26 ++
 rtl/nibble_distributor.sv | 129 ++++++++++++
 tb/tb_nibble_distributor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_distributor_pkg.sv
// Shared definitions for the nibble distributor.
//   - state_t     : FSM encoding (FILL collects nibbles, HOLD presents the frame)
//   - NIB_W       : nibble width
//   - NSLOT       : number of slot registers
//   - SLOT_FULL   : slot-valid pattern that completes a frame
//   - slot_onehot : 2-to-4 one-hot decode of a slot index
package nibble_distributor_pkg;

  localparam int NIB_W = 4;
  localparam int NSLOT = 4;
  localparam logic [NSLOT-1:0] SLOT_FULL = 4'b1111;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [NSLOT-1:0] slot_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/slot_reg4.sv
// One nibble slot register with write enable.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q to zero
//   en    : load d into q on the next rising edge
//   d     : nibble to store
//   q     : stored nibble
module slot_reg4
  import nibble_distributor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NIB_W-1:0] d,
  output logic [NIB_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nibble_distributor.sv
// Registered 1-to-4 nibble distributor.
// Accepts nibbles over a valid/ready handshake and steers each into one of
// four slot registers, either by explicit address (mode=0, slot S) or by an
// internal wrapping pointer (mode=1). Once all four slots are fresh the block
// presents them as a frame and stalls input until the consumer takes it.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   mode              : 0 = addressed by S, 1 = sequential pointer
//   S                 : slot address (addressed mode only)
//   D, in_valid       : input nibble and its valid
//   in_ready          : high in FILL, when a write can be taken
//   clr               : synchronous abort of the frame being collected
//   Q0..Q3            : slot registers
//   slot_vld          : per-slot "written since last release" flags
//   frame_valid       : high in HOLD, Q0..Q3 form a stable frame
//   frame_ready       : consumer accepts the frame
//   ovw               : one-cycle pulse after an addressed write hit a valid slot
module nibble_distributor
  import nibble_distributor_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [1:0]       S,
  input  logic [NIB_W-1:0] D,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [NIB_W-1:0] Q0,
  output logic [NIB_W-1:0] Q1,
  output logic [NIB_W-1:0] Q2,
  output logic [NIB_W-1:0] Q3,
  output logic [NSLOT-1:0] slot_vld,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             ovw
);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NSLOT-1:0] vld_q, vld_d;
  logic             ovw_q, ovw_d;

  logic             fire;
  logic [1:0]       slot;
  logic [NSLOT-1:0] wr_sel;
  logic [NIB_W-1:0] q_arr [NSLOT];

  // A write can only fire in FILL; in_ready is a pure state decode, so
  // this is the same as in_valid && in_ready without a combinational loop.
  assign fire   = in_valid && (state_q == FILL);
  assign slot   = mode ? ptr_q : S;
  assign wr_sel = fire ? slot_onehot(slot) : '0;

  // Slot data path. The data write is not blocked by clr: an aborted frame
  // still keeps whatever was written in the abort cycle.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    slot_reg4 u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (wr_sel[i]),
      .d     (D),
      .q     (q_arr[i])
    );
  end

  assign Q0       = q_arr[0];
  assign Q1       = q_arr[1];
  assign Q2       = q_arr[2];
  assign Q3       = q_arr[3];
  assign slot_vld = vld_q;
  assign ovw      = ovw_q;

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      ptr_q   <= '0;
      vld_q   <= '0;
      ovw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      ovw_q   <= ovw_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    vld_d       = vld_q;
    in_ready    = 1'b0;
    frame_valid = 1'b0;

    // Only addressed writes report an overwrite; a sequential write that
    // lands on an already-valid slot is silent.
    ovw_d = fire && !mode && (|(vld_q & wr_sel));

    if (state_q == FILL) begin
      in_ready = 1'b1;
      if (fire) begin
        vld_d = vld_q | wr_sel;
        if (mode) begin
          ptr_d = 2'(ptr_q + 2'd1);
        end
        if (vld_d == SLOT_FULL) begin
          state_d = HOLD;
        end
      end
    end else begin
      frame_valid = 1'b1;
      if (frame_ready) begin
        vld_d   = '0;
        ptr_d   = '0;
        state_d = FILL;
      end
    end

    // Abort wins over any write completion or frame release this cycle.
    if (clr) begin
      vld_d   = '0;
      ptr_d   = '0;
      state_d = FILL;
    end
  end

endmodule

// File: tb/tb_nibble_distributor.sv
// Self-checking bench for nibble_distributor: directed scenarios followed by
// randomized traffic, all compared against a slot-array reference model.
module tb_nibble_distributor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] S;
  logic [3:0] D;
  logic       in_valid;
  logic       in_ready;
  logic       clr;
  logic [3:0] Q0, Q1, Q2, Q3;
  logic [3:0] slot_vld;
  logic       frame_valid;
  logic       frame_ready;
  logic       ovw;

  nibble_distributor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .S           (S),
    .D           (D),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .clr         (clr),
    .Q0          (Q0),
    .Q1          (Q1),
    .Q2          (Q2),
    .Q3          (Q3),
    .slot_vld    (slot_vld),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .ovw         (ovw)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: four slots, a set of "fresh" flags, a pointer and a
  // flag saying whether a full frame is being held.
  logic [3:0] m_q [4];
  bit         m_fresh [4];
  int         m_ptr;
  bit         m_hold;
  bit         m_ovw;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_vld_bits();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_fresh[i];
    return v;
  endfunction

  function automatic bit m_all_fresh();
    return m_fresh[0] && m_fresh[1] && m_fresh[2] && m_fresh[3];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i]     = 4'h0;
      m_fresh[i] = 1'b0;
    end
    m_ptr  = 0;
    m_hold = 1'b0;
    m_ovw  = 1'b0;
  endtask

  task automatic model_clear_frame();
    for (int i = 0; i < 4; i++) m_fresh[i] = 1'b0;
    m_ptr  = 0;
    m_hold = 1'b0;
  endtask

  task automatic model_edge(input logic iv, input logic md, input logic [1:0] s,
                            input logic [3:0] d, input logic c, input logic fr);
    bit accept;
    int k;
    accept = iv && !m_hold;
    k      = md ? m_ptr : int'(s);
    m_ovw  = accept && !md && m_fresh[k];
    if (accept) m_q[k] = d;
    if (c) begin
      model_clear_frame();
    end else if (m_hold) begin
      if (fr) model_clear_frame();
    end else if (accept) begin
      m_fresh[k] = 1'b1;
      if (md) m_ptr = (m_ptr + 1) % 4;
      if (m_all_fresh()) m_hold = 1'b1;
    end
  endtask

  task automatic check_all();
    check("Q0", 16'(Q0), 16'(m_q[0]));
    check("Q1", 16'(Q1), 16'(m_q[1]));
    check("Q2", 16'(Q2), 16'(m_q[2]));
    check("Q3", 16'(Q3), 16'(m_q[3]));
    check("slot_vld", 16'(slot_vld), 16'(m_vld_bits()));
    check("frame_valid", 16'(frame_valid), 16'(m_hold));
    check("in_ready", 16'(in_ready), 16'(!m_hold));
    check("ovw", 16'(ovw), 16'(m_ovw));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then check.
  task automatic step(input logic iv, input logic md, input logic [1:0] s,
                      input logic [3:0] d, input logic c, input logic fr);
    in_valid    = iv;
    mode        = md;
    S           = s;
    D           = d;
    clr         = c;
    frame_ready = fr;
    @(posedge clk);
    model_edge(iv, md, s, d, c, fr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n       = 1'b1;
    mode        = 1'b0;
    S           = 2'd0;
    D           = 4'h0;
    in_valid    = 1'b0;
    clr         = 1'b0;
    frame_ready = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Reset mid-fill: two sequential writes, then asynchronous reset.
    step(1'b1, 1'b1, 2'd0, 4'h7, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'h8, 1'b0, 1'b0);
    check("mid_fill_vld", 16'(slot_vld), 16'h0003);
    #1;
    apply_reset();
    check("rst_vld", 16'(slot_vld), 16'h0000);
    check("rst_ready", 16'(in_ready), 16'h0001);
    step(1'b1, 1'b1, 2'd0, 4'h9, 1'b0, 1'b0);
    check("rst_ptr_to_q0", 16'(Q0), 16'h0009);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 1'b0);

    // Sequential fill 1,2,3,4.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 2'd0, 4'(i), 1'b0, 1'b0);
    check("seq_frame", {Q3, Q2, Q1, Q0}, 16'h4321);
    check("seq_fv", 16'(frame_valid), 16'h0001);
    check("seq_ready", 16'(in_ready), 16'h0000);

    // HOLD backpressure: writes ignored, then release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 1'b0);
    check("hold_frame", {Q3, Q2, Q1, Q0}, 16'h4321);
    step(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, 1'b1);
    check("release_ready", 16'(in_ready), 16'h0001);
    check("release_vld", 16'(slot_vld), 16'h0000);
    check("release_keep", {Q3, Q2, Q1, Q0}, 16'h4321);

    // Addressed overwrite.
    step(1'b1, 1'b0, 2'd2, 4'hA, 1'b0, 1'b0);
    check("ovw_first", 16'(ovw), 16'h0000);
    step(1'b1, 1'b0, 2'd2, 4'h5, 1'b0, 1'b0);
    check("ovw_q2", 16'(Q2), 16'h0005);
    check("ovw_vld", 16'(slot_vld), 16'h0004);
    check("ovw_pulse", 16'(ovw), 16'h0001);
    step(1'b1, 1'b0, 2'd0, 4'h1, 1'b0, 1'b0);
    check("ovw_drop", 16'(ovw), 16'h0000);
    step(1'b1, 1'b0, 2'd1, 4'h2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 4'h3, 1'b0, 1'b0);
    check("addr_frame", {Q3, Q2, Q1, Q0}, 16'h3521);
    check("addr_fv", 16'(frame_valid), 16'h0001);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);

    // Pointer wrap through clr.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 4'(8 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd0, 4'(12 - i), 1'b0, 1'b0);
    check("wrap_frame", {Q3, Q2, Q1, Q0}, 16'h9ABC);
    check("wrap_fv", 16'(frame_valid), 16'h0001);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0, 1'b1);

    // clr in the same cycle as the fourth write.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 4'(1 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'hE, 1'b1, 1'b0);
    check("clr_vld", 16'(slot_vld), 16'h0000);
    check("clr_fv", 16'(frame_valid), 16'h0000);
    check("clr_q3", 16'(Q3), 16'h000E);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 2) == 0));
      if (n == 1500) begin
        #1;
        apply_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
